// File: rtl/game_pkg.sv
// game_pkg
// Shared definitions for the collision scanner: bullet colour codes, the
// per-colour damage table, the scanner FSM state encoding and the
// "keep every bullet" mask value.
package game_pkg;

    localparam logic [2:0] COLOR_WHITE = 3'b000;
    localparam logic [2:0] COLOR_GREEN = 3'b001;
    localparam logic [2:0] COLOR_BLUE  = 3'b010;

    // indexCollide value that removes nothing
    localparam logic [2:0] KEEP_ALL = 3'b111;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_CHECK = 3'd2,
        ST_APPLY = 3'd3,
        ST_SPLIT = 3'd4
    } scan_state_t;

    // Damage dealt by one hit of the given colour; unknown codes are harmless
    function automatic logic [1:0] damage_of(input logic [2:0] color);
        case (color)
            COLOR_WHITE: damage_of = 2'd1;
            COLOR_GREEN: damage_of = 2'd2;
            COLOR_BLUE:  damage_of = 2'd3;
            default:     damage_of = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/aabb_overlap.sv
// aabb_overlap
// Purely combinational axis-aligned box overlap test.
// Ports:
//   a_pos, a_size : box A origin {x,y} and extent {w,h}, 8 bits per field
//   b_pos, b_size : box B, same packing
//   overlap       : 1 when the boxes share interior area (touching edges do
//                   not count)
module aabb_overlap (
    input  logic [15:0] a_pos,
    input  logic [15:0] a_size,
    input  logic [15:0] b_pos,
    input  logic [15:0] b_size,
    output logic        overlap
);

    // Far edges are formed in 9 bits so a box near 0xFF never wraps around
    logic [8:0] a_x_end, a_y_end, b_x_end, b_y_end;

    assign a_x_end = {1'b0, a_pos[15:8]} + {1'b0, a_size[15:8]};
    assign a_y_end = {1'b0, a_pos[7:0]}  + {1'b0, a_size[7:0]};
    assign b_x_end = {1'b0, b_pos[15:8]} + {1'b0, b_size[15:8]};
    assign b_y_end = {1'b0, b_pos[7:0]}  + {1'b0, b_size[7:0]};

    assign overlap = ({1'b0, b_pos[15:8]} < a_x_end) &&
                     ({1'b0, a_pos[15:8]} < b_x_end) &&
                     ({1'b0, b_pos[7:0]}  < a_y_end) &&
                     ({1'b0, a_pos[7:0]}  < b_y_end);

endmodule

// File: rtl/collision_scanner.sv
// collision_scanner
// Once per frame tick, walks the bullet slots, tests each live bullet
// against the player box, applies the summed damage to hp and reports which
// bullets must be removed.
// Ports:
//   clk, rst              : clock, asynchronous active-high reset
//   start, isRun          : frame tick request / game running (low aborts)
//   player_pos/size       : player box {x,y} / {w,h}
//   index2                : slot address to the bullet store (combinational read)
//   position2, size2,
//   color2, isRender2     : slot data returned for index2
//   indexCollide          : keep-mask, bit i = 0 removes bullet i (idles 3'b111)
//   isComplete            : one-cycle pulse when the scan result is presented
//   hp, isDead, busy      : player hit points, hp == 0, scan in progress
// Configuration: define GREEN_HEAL_EN to make green bullets heal 2 hp
// (capped at HP_INIT) instead of dealing damage.
module collision_scanner
    import game_pkg::*;
#(
    parameter int NUM_BULLETS = 3,
    parameter int HP_INIT     = 100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        isRun,
    input  logic [15:0] player_pos,
    input  logic [15:0] player_size,
    output logic [2:0]  index2,
    input  logic [15:0] position2,
    input  logic [15:0] size2,
    input  logic [2:0]  color2,
    input  logic        isRender2,
    output logic [2:0]  indexCollide,
    output logic        isComplete,
    output logic [7:0]  hp,
    output logic        isDead,
    output logic        busy
);

    localparam logic [7:0] HP_RESET  = HP_INIT[7:0];
    localparam logic [2:0] LAST_SLOT = 3'(NUM_BULLETS - 1);
    localparam logic [2:0] FULL_MASK = 3'((1 << NUM_BULLETS) - 1);
    localparam logic [2:0] TOP_BIT   = 3'(1 << (NUM_BULLETS - 1));

    scan_state_t state_reg;
    logic [2:0]  slot_reg;
    logic [2:0]  hitmask_reg;
    logic [7:0]  dmg_reg;
`ifdef GREEN_HEAL_EN
    logic [7:0]  heal_reg;
`endif
    logic [7:0]  hp_reg;
    logic [2:0]  index_collide_reg;
    logic        complete_reg;

    logic        overlap;
    logic        hit;
    logic [7:0]  hp_next;
    int          hp_net;

    aabb_overlap u_overlap (
        .a_pos   (player_pos),
        .a_size  (player_size),
        .b_pos   (position2),
        .b_size  (size2),
        .overlap (overlap)
    );

    assign hit = overlap && isRender2;

    // Damage and healing net against each other; a dead player stays at 0
    always_comb begin
`ifdef GREEN_HEAL_EN
        hp_net = int'(hp_reg) + int'(heal_reg) - int'(dmg_reg);
`else
        hp_net = int'(hp_reg) - int'(dmg_reg);
`endif
        hp_next = hp_net[7:0];
        if (hp_reg == 8'd0 || hp_net <= 0) begin
            hp_next = 8'd0;
        end else if (hp_net > HP_INIT) begin
            hp_next = HP_RESET;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg         <= ST_IDLE;
            slot_reg          <= 3'd0;
            hitmask_reg       <= 3'd0;
            dmg_reg           <= 8'd0;
`ifdef GREEN_HEAL_EN
            heal_reg          <= 8'd0;
`endif
            hp_reg            <= HP_RESET;
            index_collide_reg <= KEEP_ALL;
            complete_reg      <= 1'b0;
        end else begin
            // Result outputs are single-cycle events
            index_collide_reg <= KEEP_ALL;
            complete_reg      <= 1'b0;

            if (state_reg != ST_IDLE && !isRun) begin
                // Abort: drop everything gathered so far
                state_reg   <= ST_IDLE;
                slot_reg    <= 3'd0;
                hitmask_reg <= 3'd0;
                dmg_reg     <= 8'd0;
`ifdef GREEN_HEAL_EN
                heal_reg    <= 8'd0;
`endif
            end else begin
                case (state_reg)
                    ST_IDLE: begin
                        if (start && isRun) begin
                            state_reg   <= ST_ADDR;
                            slot_reg    <= 3'd0;
                            hitmask_reg <= 3'd0;
                            dmg_reg     <= 8'd0;
`ifdef GREEN_HEAL_EN
                            heal_reg    <= 8'd0;
`endif
                        end
                    end
                    // index2 is already presented; the store answers next cycle
                    ST_ADDR: state_reg <= ST_CHECK;
                    ST_CHECK: begin
                        if (hit) begin
                            hitmask_reg[slot_reg] <= 1'b1;
`ifdef GREEN_HEAL_EN
                            if (color2 == COLOR_GREEN) begin
                                heal_reg <= heal_reg + 8'd2;
                            end else begin
                                dmg_reg <= dmg_reg + 8'(damage_of(color2));
                            end
`else
                            dmg_reg <= dmg_reg + 8'(damage_of(color2));
`endif
                        end
                        if (slot_reg == LAST_SLOT) begin
                            slot_reg  <= 3'd0;
                            state_reg <= ST_APPLY;
                        end else begin
                            slot_reg  <= slot_reg + 3'd1;
                            state_reg <= ST_ADDR;
                        end
                    end
                    ST_APPLY: begin
                        hp_reg <= hp_next;
                        if (hitmask_reg == FULL_MASK) begin
                            // The bullet store cannot take an all-zero mask, so
                            // removal is split: everything but the top slot now,
                            // the top slot next cycle
                            index_collide_reg <= ~FULL_MASK | TOP_BIT;
                            state_reg         <= ST_SPLIT;
                        end else begin
                            index_collide_reg <= ~hitmask_reg;
                            complete_reg      <= 1'b1;
                            state_reg         <= ST_IDLE;
                        end
                    end
                    ST_SPLIT: begin
                        index_collide_reg <= ~TOP_BIT;
                        complete_reg      <= 1'b1;
                        state_reg         <= ST_IDLE;
                    end
                    default: state_reg <= ST_IDLE;
                endcase
            end
        end
    end

    assign index2       = slot_reg;
    assign indexCollide = index_collide_reg;
    assign isComplete   = complete_reg;
    assign hp           = hp_reg;
    assign isDead       = (hp_reg == 8'd0);
    assign busy         = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_collision_scanner.sv
// Directed bench for collision_scanner (default build, 3 slots, HP 100).
module tb_collision_scanner;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        isRun;
    logic [15:0] player_pos;
    logic [15:0] player_size;
    logic [2:0]  index2;
    logic [15:0] position2;
    logic [15:0] size2;
    logic [2:0]  color2;
    logic        isRender2;
    logic [2:0]  indexCollide;
    logic        isComplete;
    logic [7:0]  hp;
    logic        isDead;
    logic        busy;

    logic [15:0] b_pos    [3];
    logic [15:0] b_size   [3];
    logic [2:0]  b_color  [3];
    logic        b_render [3];

    logic [2:0]  ic_log  [10];
    logic        cp_log  [10];
    logic [2:0]  idx_log [10];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    collision_scanner dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .isRun        (isRun),
        .player_pos   (player_pos),
        .player_size  (player_size),
        .index2       (index2),
        .position2    (position2),
        .size2        (size2),
        .color2       (color2),
        .isRender2    (isRender2),
        .indexCollide (indexCollide),
        .isComplete   (isComplete),
        .hp           (hp),
        .isDead       (isDead),
        .busy         (busy)
    );

    // Bullet store with combinational read
    always_comb begin
        position2 = 16'h0000;
        size2     = 16'h0000;
        color2    = 3'b000;
        isRender2 = 1'b0;
        if (index2 < 3'd3) begin
            position2 = b_pos[index2];
            size2     = b_size[index2];
            color2    = b_color[index2];
            isRender2 = b_render[index2];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
            $display("ok   %s got=%0h", tag, got);
        end else begin
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic clear_bullets();
        for (int i = 0; i < 3; i++) begin
            b_pos[i]    = 16'h0000;
            b_size[i]   = 16'h0101;
            b_color[i]  = 3'b000;
            b_render[i] = 1'b1;
        end
    endtask

    task automatic set_bullet(input int i, input logic [15:0] pos, input logic [15:0] sz,
                              input logic [2:0] col, input logic ren);
        b_pos[i]    = pos;
        b_size[i]   = sz;
        b_color[i]  = col;
        b_render[i] = ren;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Start pulse sampled at edge E0; log outputs #1 after E0..E9
    task automatic scan();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        ic_log[0] = indexCollide; cp_log[0] = isComplete; idx_log[0] = index2;
        for (int k = 1; k < 10; k++) begin
            @(posedge clk);
            #1;
            ic_log[k]  = indexCollide;
            cp_log[k]  = isComplete;
            idx_log[k] = index2;
        end
    endtask

    initial begin
        rst         = 1'b1;
        start       = 1'b0;
        isRun       = 1'b1;
        player_pos  = 16'h4040;
        player_size = 16'h1010;
        clear_bullets();
        #2;
        check("rst_hp", 32'(hp), 32'd100);
        check("rst_dead", 32'(isDead), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ic", 32'(indexCollide), 32'h7);
        check("rst_cmp", 32'(isComplete), 32'd0);
        check("rst_idx", 32'(index2), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Single white hit on slot 0
        set_bullet(0, 16'h4848, 16'h1010, 3'b000, 1'b1);
        scan();
        check("t1_busy", 32'(busy), 32'd0);
        check("t1_idx2", 32'(idx_log[2]), 32'd1);
        check("t1_idx4", 32'(idx_log[4]), 32'd2);
        check("t1_cmp6", 32'(cp_log[6]), 32'd0);
        check("t1_ic6", 32'(ic_log[6]), 32'h7);
        check("t1_cmp7", 32'(cp_log[7]), 32'd1);
        check("t1_ic7", 32'(ic_log[7]), 32'h6);
        check("t1_cmp8", 32'(cp_log[8]), 32'd0);
        check("t1_ic8", 32'(ic_log[8]), 32'h7);
        check("t1_hp", 32'(hp), 32'd99);

        // Edge touch on slot 1 is not a hit
        clear_bullets();
        set_bullet(1, 16'h5048, 16'h1010, 3'b000, 1'b1);
        scan();
        check("t2_cmp7", 32'(cp_log[7]), 32'd1);
        check("t2_ic7", 32'(ic_log[7]), 32'h7);
        check("t2_hp", 32'(hp), 32'd99);

        // All three hit: split removal
        do_reset();
        check("t3_rst_hp", 32'(hp), 32'd100);
        set_bullet(0, 16'h4848, 16'h1010, 3'b000, 1'b1);
        set_bullet(1, 16'h4444, 16'h0404, 3'b001, 1'b1);
        set_bullet(2, 16'h3C3C, 16'h0808, 3'b010, 1'b1);
        scan();
        check("t3_ic7", 32'(ic_log[7]), 32'h4);
        check("t3_cmp7", 32'(cp_log[7]), 32'd0);
        check("t3_ic8", 32'(ic_log[8]), 32'h3);
        check("t3_cmp8", 32'(cp_log[8]), 32'd1);
        check("t3_ic9", 32'(ic_log[9]), 32'h7);
        check("t3_hp", 32'(hp), 32'd94);

        // Not rendered: no hit
        clear_bullets();
        set_bullet(0, 16'h4848, 16'h1010, 3'b010, 1'b0);
        scan();
        check("t4_ic7", 32'(ic_log[7]), 32'h7);
        check("t4_hp", 32'(hp), 32'd94);

        // Drain hp to 2: 15 all-hit scans (-90) then two white hits
        set_bullet(0, 16'h4848, 16'h1010, 3'b000, 1'b1);
        set_bullet(1, 16'h4444, 16'h0404, 3'b001, 1'b1);
        set_bullet(2, 16'h3C3C, 16'h0808, 3'b010, 1'b1);
        for (int n = 0; n < 15; n++) scan();
        check("t5_hp4", 32'(hp), 32'd4);
        clear_bullets();
        set_bullet(0, 16'h4848, 16'h1010, 3'b000, 1'b1);
        scan();
        scan();
        check("t5_hp2", 32'(hp), 32'd2);
        check("t5_alive", 32'(isDead), 32'd0);
        clear_bullets();
        set_bullet(2, 16'h3C3C, 16'h0808, 3'b010, 1'b1);
        scan();
        check("t5_ic7", 32'(ic_log[7]), 32'h3);
        check("t5_hp0", 32'(hp), 32'd0);
        check("t5_dead", 32'(isDead), 32'd1);
        scan();
        check("t5_dead_cmp", 32'(cp_log[7]), 32'd1);
        check("t5_dead_ic", 32'(ic_log[7]), 32'h3);
        check("t5_dead_hp", 32'(hp), 32'd0);

        // isRun dropped in cycle 3 of a hit scan
        do_reset();
        clear_bullets();
        set_bullet(0, 16'h4848, 16'h1010, 3'b000, 1'b1);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        isRun = 1'b0;
        @(posedge clk);
        #1;
        check("t6_busy", 32'(busy), 32'd0);
        begin
            int seen_cmp = 0;
            for (int k = 0; k < 8; k++) begin
                @(posedge clk);
                #1;
                if (isComplete || indexCollide != 3'b111) seen_cmp++;
            end
            check("t6_no_result", 32'(seen_cmp), 32'd0);
        end
        check("t6_hp", 32'(hp), 32'd100);
        isRun = 1'b1;

        // Reset mid-scan after a hit scan has lowered hp
        scan();
        check("t7_pre_hp", 32'(hp), 32'd99);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("t7_mid_idx", 32'(index2), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("t7_rst_hp", 32'(hp), 32'd100);
        check("t7_rst_busy", 32'(busy), 32'd0);
        check("t7_rst_idx", 32'(index2), 32'd0);
        check("t7_rst_ic", 32'(indexCollide), 32'h7);
        @(negedge clk);
        rst = 1'b0;
        scan();
        check("t7_after_ic7", 32'(ic_log[7]), 32'h6);
        check("t7_after_cmp7", 32'(cp_log[7]), 32'd1);
        check("t7_after_hp", 32'(hp), 32'd99);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
